// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - mdu_op_e     : 3-bit operation codes presented on mult_div_unit.op
//   - mdu_state_e  : sequencing states of mult_div_unit
//   - MDU_MUL_CYCLES : default busy length of MULT/MULTU
//   - abs_if()     : magnitude of a 32-bit operand when the op is signed
package mult_div_unit_pkg;

   typedef enum logic [2:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } mdu_state_e;

   localparam int MDU_MUL_CYCLES = 5;

   // Two's-complement magnitude when sgn is set; 0x80000000 maps to itself,
   // which is the correct unsigned magnitude.
   function automatic logic [31:0] abs_if(input logic sgn, input logic [31:0] v);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: iterative unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   load                : latch dividend/divisor and restart (one-cycle pulse)
//   dividend, divisor   : unsigned operands, sampled only on load
//   quotient, remainder : results, final once done is high
//   done                : all STEPS iterations have been performed
module mdu_divider
   import mult_div_unit_pkg::*;
#(
   parameter int STEPS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        done
);

   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dvs_q, dvs_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [32:0] shifted;
   logic [32:0] diff;

   always_comb begin
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      // The quotient register doubles as the dividend shift register: its MSB
      // feeds the partial remainder while quotient bits enter at the LSB.
      shifted = {rem_q, quo_q[31]};
      diff    = shifted - {1'b0, dvs_q};
      if (load) begin
         quo_d = dividend;
         rem_d = 32'd0;
         dvs_d = divisor;
         cnt_d = 6'(STEPS);
      end else if (cnt_q != 6'd0) begin
         cnt_d = cnt_q - 6'd1;
         if (!diff[32]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
         end else begin
            rem_d = shifted[31:0];
            quo_d = {quo_q[30:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         quo_q <= 32'd0;
         rem_q <= 32'd0;
         dvs_q <= 32'd0;
         cnt_q <= 6'd0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign done      = (cnt_q == 6'd0);

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   A, B       : forwarded rs/rt operands (dividend/multiplicand, divisor/multiplier)
//   op, start  : operation code, qualified by start; honoured only when idle
//   busy       : operation in flight, HI/LO not yet final
//   hi, lo     : architectural HI/LO registers
// Handshake: start is a one-cycle request that is accepted only on an edge
// where busy is low; a request seen while busy is dropped, not queued.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int MUL_CYCLES = MDU_MUL_CYCLES,
   parameter int DIV_BITS   = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  op,
   input  logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdu_state_e  state_q, state_d;
   logic [5:0]  counter_q, counter_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [63:0] prod_q, prod_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;

   logic        sgn_op;
   logic [63:0] a_ext, b_ext, mul_full;
   logic        div_load;
   logic [31:0] div_quo, div_rem;
   logic        div_done;

   // Sign-extend only for signed ops; the low 64 bits of the 64x64 product are
   // then the correct signed or unsigned 32x32 product.
   assign sgn_op   = (op == MDU_MULT) || (op == MDU_DIV);
   assign a_ext    = {{32{sgn_op & A[31]}}, A};
   assign b_ext    = {{32{sgn_op & B[31]}}, B};
   assign mul_full = a_ext * b_ext;

   mdu_divider #(.STEPS(DIV_BITS)) u_divider (
      .clk       (clk),
      .reset     (reset),
      .load      (div_load),
      .dividend  (abs_if(sgn_op, A)),
      .divisor   (abs_if(sgn_op, B)),
      .quotient  (div_quo),
      .remainder (div_rem),
      .done      (div_done)
   );

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      prod_d    = prod_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      div_load  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (op)
                  MDU_MULT, MDU_MULTU: begin
                     prod_d    = mul_full;
                     counter_d = 6'(MUL_CYCLES);
                     state_d   = ST_MUL;
                  end
                  MDU_DIV, MDU_DIVU: begin
                     // Divide by zero leaves HI/LO untouched and never goes busy.
                     if (B != 32'd0) begin
                        div_load  = 1'b1;
                        qneg_d    = sgn_op & (A[31] ^ B[31]);
                        rneg_d    = sgn_op & A[31];
                        counter_d = 6'(DIV_BITS);
                        state_d   = ST_DIV;
                     end
                  end
                  MDU_MTHI: hi_d = A;
                  MDU_MTLO: lo_d = A;
                  default: ;
               endcase
            end
         end
         ST_MUL: begin
            if (counter_q == 6'd1) begin
               {hi_d, lo_d} = prod_q;
               counter_d    = 6'd0;
               state_d      = ST_IDLE;
            end else begin
               counter_d = counter_q - 6'd1;
            end
         end
         ST_DIV: begin
            // The divider steps on the same edges, so its last step lands on
            // the edge that moves us to FIX.
            if (counter_q == 6'd1) begin
               counter_d = 6'd0;
               state_d   = ST_FIX;
            end else begin
               counter_d = counter_q - 6'd1;
            end
         end
         ST_FIX: begin
            if (div_done) begin
               lo_d = qneg_q ? (~div_quo + 32'd1) : div_quo;
               hi_d = rneg_q ? (~div_rem + 32'd1) : div_rem;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         counter_q <= 6'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         prod_q    <= 64'd0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         prod_q    <= prod_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, alongside the ALU.
- Consumes the same forwarded operands A/B that feed the ALU.
- Owns the architectural HI/LO registers.
- Drives a busy flag that the hazard unit uses to stall any MULT/DIV/MFHI/MFLO/MTHI/MTLO that arrives while an operation is in flight.

Parameters:
- MUL_CYCLES, 5: busy cycles for MULT/MULTU (range 1..63).
- DIV_BITS, 32: iterations of the restoring divider. Fixed at 32; the parameter exists for the bench only.

Ports:
- clk  input  1  Rising-edge clock.
- reset  input  1  Synchronous, active-high reset.
- A  input  32  Operand rs (dividend / multiplicand).
- B  input  32  Operand rt (divisor / multiplier).
- op  input  3  Operation code; `mdu*` constants in constants.v.
- start  input  1  Qualifies op for this cycle.
- busy  output  1  Operation in flight; HI/LO not yet final.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Op codes:
  - mduNone=0, mduMult=1, mduMultu=2, mduDiv=3, mduDivu=4, mduMthi=5, mduMtlo=6.
  - Codes 7 and mduNone are no-ops.
- Reset (synchronous, active-high):
  - hi=0, lo=0, busy=0, state=IDLE, counter=0.
  - Reset during MUL/DIV/FIX aborts the operation; no HI/LO write.
- Accept rule:
  - start is honoured only in IDLE.
  - start while busy=1 is ignored, with no effect on state.
  - Upstream guarantees it stalls instead of issuing while busy.
- MTHI/MTLO:
  - On the accept edge, hi<=A (or lo<=A).
  - busy stays 0; the new value is visible the next cycle.
- States: IDLE, MUL, DIV, FIX.
- MULT/MULTU:
  - Accept edge: the 64-bit product is computed (signed or unsigned) and held in an internal register; counter<=MUL_CYCLES; state<=MUL; busy<=1.
  - Each cycle in MUL the counter decrements.
  - On the edge where the counter reaches 1: {hi,lo}<=product, busy<=0, state<=IDLE.
  - busy is high for exactly MUL_CYCLES cycles. The new HI/LO are readable in the first cycle busy=0.
- DIV/DIVU:
  - B==0: no-op. hi/lo unchanged, busy stays 0, state stays IDLE.
  - Otherwise, accept edge:
    - Latch |A| and |B| (signed) or A and B (unsigned).
    - Latch the result sign (A[31]^B[31]) and the remainder sign (A[31]) for signed ops.
    - state<=DIV, busy<=1, counter<=DIV_BITS.
  - DIV: one restoring-division step per cycle (shift partial remainder left, trial-subtract, set quotient bit). DIV_BITS cycles in total, then state<=FIX.
  - FIX (1 cycle):
    - Negate the quotient if the result-sign bit is set.
    - Negate the remainder if the remainder-sign bit is set.
    - lo<=quotient, hi<=remainder, busy<=0, state<=IDLE.
  - busy is high for DIV_BITS+1 = 33 cycles.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0. This is the natural wrap; no trap.
- While busy:
  - hi/lo hold their pre-operation values.
  - A/B/op changes have no effect; all operands are latched at accept.
- Simultaneous events: a start in the same cycle that busy falls is ignored. busy is a registered output, so the upstream stall is still asserted in that cycle.

Decomposition:
- constants.v gains:
  - `mduNone..`mduMtlo (3-bit).
  - `mduMulCycles (5).
- One sub-module: mdu_divider. It is an iterative unsigned restoring divider:
  - Inputs: clk, reset, load, dividend[31:0], divisor[31:0].
  - Outputs: quotient[31:0], remainder[31:0], done.
- mult_div_unit handles sign magnitude, the FIX correction, the multiply path and the HI/LO registers.

Test Plan:
- Reset then idle → hi=0, lo=0, busy=0. Assert reset mid-DIV at cycle 10 → busy=0 next cycle, hi/lo keep their pre-op values.
- MULT A=0xFFFFFFFF, B=0x00000002 → busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 → busy 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=100, B=7 → lo=0x0000000E, hi=0x00000002.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 5/0 → busy never rises, hi/lo unchanged.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on consecutive cycles → hi/lo updated one cycle after each, busy=0 throughout.
- Start MULTU 3×4, then re-pulse start with DIV 1/1 while busy → second request ignored, final hi=0, lo=0x0000000C. Start in the cycle busy falls is ignored.
